project_mux_gen: RTL and testbench

Parametrised multi-project selector for the user area: owns the pad bank and hands it to one of NUM_SLOTS independent projects at a time. Configured over the management Wishbone bus. Adds a timed, glitch-free switchover (pads tristated, all slots held in reset for RST_HOLD cycles) and shadowed per-project settings that apply only on slot entry. Sits between the pads and the project macros in user_project_wrapper.

---
 rtl/project_mux_gen.sv | 163 ++++++++++++++++
 tb/tb_project_mux_gen.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/project_mux_gen.sv
// Pad-bank owner for the user area: hands the pads to one of NUM_SLOTS projects at a time,
// with a timed tristate/reset switchover and shadowed per-project settings, configured over Wishbone.
//
// state | meaning
// IDLE  | no project selected, pads tristated, all slots held in reset
// DRAIN | switchover hold: pads tristated, all slots in reset for RST_HOLD cycles
// RUN   | active slot owns the pads, only its reset is released
module project_mux_gen #(
    parameter int          NUM_SLOTS  = 16,
    parameter int          IO_W       = 33,
    parameter int          SETTINGS_W = 32,
    parameter int          RST_HOLD   = 16,
    parameter logic [31:0] BASE_ADDR  = 32'h3000_0000
) (
    input  logic                      wb_clk_i,
    input  logic                      wb_rst_i,
    input  logic                      wbs_cyc_i,
    input  logic                      wbs_stb_i,
    input  logic                      wbs_we_i,
    input  logic [31:0]               wbs_adr_i,
    input  logic [31:0]               wbs_dat_i,
    output logic                      wbs_ack_o,
    output logic [31:0]               wbs_dat_o,
    input  logic [NUM_SLOTS*IO_W-1:0] slot_do,
    input  logic [NUM_SLOTS*IO_W-1:0] slot_oeb,
    output logic [IO_W-1:0]           io_out,
    output logic [IO_W-1:0]           io_oeb,
    output logic [NUM_SLOTS-1:0]      slot_rst_n,
    output logic [SETTINGS_W-1:0]     custom_settings,
    output logic [2:0]                irq
);

    localparam int                CNT_W    = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;
    localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(RST_HOLD - 1);
    localparam logic [8:0]        SLOT_LIM = 9'(NUM_SLOTS);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DRAIN = 2'd1,
        S_RUN   = 2'd2
    } state_t;

    state_t               state;
    logic [CNT_W-1:0]     cnt;
    logic                 ctrl_en;
    logic [7:0]           ctrl_slot;
    logic [31:0]          settings_q;
    logic [7:0]           active;
    logic                 bad_sel;
    logic                 irq_run_q;
    logic                 irq_bad_q;

    logic                 wb_req;
    logic                 wb_acc;
    logic                 wr_ctrl;
    logic                 wr_set;
    logic                 new_bad;
    logic                 tgt_ok;
    logic [31:0]          rdata;
    logic [NUM_SLOTS-1:0] tgt_onehot;
    logic                 unused_adr;

    assign unused_adr = &{1'b0, wbs_adr_i[1:0]};

    // A held request is only accepted while ack is low, so it acks every other cycle.
    assign wb_req  = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:4] == BASE_ADDR[31:4]);
    assign wb_acc  = wb_req & ~wbs_ack_o;
    assign wr_ctrl = wb_acc & wbs_we_i & (wbs_adr_i[3:2] == 2'd0);
    assign wr_set  = wb_acc & wbs_we_i & (wbs_adr_i[3:2] == 2'd1);
    assign new_bad = wbs_dat_i[31] & ({1'b0, wbs_dat_i[7:0]} >= SLOT_LIM);
    assign tgt_ok  = ctrl_en & ({1'b0, ctrl_slot} < SLOT_LIM);
    assign irq     = {1'b0, irq_bad_q, irq_run_q};

    always_comb begin
        rdata = '0;
        case (wbs_adr_i[3:2])
            2'd0:    rdata = {ctrl_en, 23'd0, ctrl_slot};
            2'd1:    rdata = settings_q;
            2'd2:    rdata = {15'd0, bad_sel, active, 6'd0, state};
            default: rdata = '0;
        endcase
    end

    always_comb begin
        tgt_onehot = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            tgt_onehot[i] = (ctrl_slot == 8'(i));
        end
    end

    // Pads follow the active slot only in RUN; the index is registered so the mux cannot glitch between slots.
    always_comb begin
        io_out = '0;
        io_oeb = '1;
        if (state == S_RUN) begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                if (active == 8'(i)) begin
                    io_out = slot_do[i*IO_W +: IO_W];
                    io_oeb = slot_oeb[i*IO_W +: IO_W];
                end
            end
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state           <= S_IDLE;
            cnt             <= '0;
            ctrl_en         <= 1'b0;
            ctrl_slot       <= '0;
            settings_q      <= '0;
            active          <= '0;
            bad_sel         <= 1'b0;
            irq_run_q       <= 1'b0;
            irq_bad_q       <= 1'b0;
            wbs_ack_o       <= 1'b0;
            wbs_dat_o       <= '0;
            slot_rst_n      <= '0;
            custom_settings <= '0;
        end else begin
            wbs_ack_o <= wb_acc;
            wbs_dat_o <= (wb_acc & ~wbs_we_i) ? rdata : '0;
            irq_run_q <= 1'b0;
            irq_bad_q <= 1'b0;

            if (wr_set) begin
                settings_q <= wbs_dat_i;
            end

            // A CTRL write always restarts the switchover, even on the cycle the hold would expire.
            if (wr_ctrl) begin
                ctrl_en    <= wbs_dat_i[31];
                ctrl_slot  <= wbs_dat_i[7:0];
                bad_sel    <= new_bad;
                irq_bad_q  <= new_bad & ~bad_sel;
                state      <= S_DRAIN;
                cnt        <= CNT_LOAD;
                slot_rst_n <= '0;
            end else begin
                case (state)
                    S_DRAIN: begin
                        if (cnt == '0) begin
                            if (tgt_ok) begin
                                state           <= S_RUN;
                                active          <= ctrl_slot;
                                slot_rst_n      <= tgt_onehot;
                                custom_settings <= SETTINGS_W'(settings_q);
                                irq_run_q       <= 1'b1;
                            end else begin
                                state           <= S_IDLE;
                                custom_settings <= '0;
                            end
                        end else begin
                            cnt <= cnt - 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_project_mux_gen.sv
// Self-checking bench for project_mux_gen: directed switchover scenarios followed by random
// bus traffic, every cycle compared against a deadline-based behavioural model.
module tb_project_mux_gen;

    localparam int          NUM_SLOTS  = 16;
    localparam int          IO_W       = 33;
    localparam int          SETTINGS_W = 32;
    localparam int          RST_HOLD   = 16;
    localparam logic [31:0] BASE       = 32'h3000_0000;

    logic                      wb_clk_i;
    logic                      wb_rst_i;
    logic                      wbs_cyc_i;
    logic                      wbs_stb_i;
    logic                      wbs_we_i;
    logic [31:0]               wbs_adr_i;
    logic [31:0]               wbs_dat_i;
    logic                      wbs_ack_o;
    logic [31:0]               wbs_dat_o;
    logic [NUM_SLOTS*IO_W-1:0] slot_do;
    logic [NUM_SLOTS*IO_W-1:0] slot_oeb;
    logic [IO_W-1:0]           io_out;
    logic [IO_W-1:0]           io_oeb;
    logic [NUM_SLOTS-1:0]      slot_rst_n;
    logic [SETTINGS_W-1:0]     custom_settings;
    logic [2:0]                irq;

    project_mux_gen #(
        .NUM_SLOTS (NUM_SLOTS),
        .IO_W      (IO_W),
        .SETTINGS_W(SETTINGS_W),
        .RST_HOLD  (RST_HOLD),
        .BASE_ADDR (BASE)
    ) dut (
        .wb_clk_i       (wb_clk_i),
        .wb_rst_i       (wb_rst_i),
        .wbs_cyc_i      (wbs_cyc_i),
        .wbs_stb_i      (wbs_stb_i),
        .wbs_we_i       (wbs_we_i),
        .wbs_adr_i      (wbs_adr_i),
        .wbs_dat_i      (wbs_dat_i),
        .wbs_ack_o      (wbs_ack_o),
        .wbs_dat_o      (wbs_dat_o),
        .slot_do        (slot_do),
        .slot_oeb       (slot_oeb),
        .io_out         (io_out),
        .io_oeb         (io_oeb),
        .slot_rst_n     (slot_rst_n),
        .custom_settings(custom_settings),
        .irq            (irq)
    );

    initial wb_clk_i = 1'b0;
    always #5 wb_clk_i = ~wb_clk_i;

    int          n_total = 0;
    int          n_bad   = 0;
    int          cyc_n   = 0;
    int          irq0_seen = 0;

    // Model: state 0 idle, 1 drain, 2 run; drain ends at an absolute cycle deadline.
    int          m_state;
    int          m_deadline;
    logic [7:0]  m_active;
    logic [31:0] m_ctrl;
    logic [31:0] m_staged;
    logic [31:0] m_cs;
    logic        m_bad;
    logic        m_ack;
    logic        m_irq0;
    logic        m_irq1;
    logic [31:0] m_dat;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h cycle=%0d", tag, got, exp, cyc_n);
        end
    endtask

    function automatic logic [31:0] model_read(input logic [1:0] a);
        case (a)
            2'd0:    return m_ctrl;
            2'd1:    return m_staged;
            2'd2:    return (32'(m_bad) << 16) | (32'(m_active) << 8) | 32'(m_state);
            default: return 32'd0;
        endcase
    endfunction

    task automatic model_reset();
        m_state  = 0;
        m_active = '0;
        m_ctrl   = '0;
        m_staged = '0;
        m_cs     = '0;
        m_bad    = 1'b0;
        m_ack    = 1'b0;
        m_irq0   = 1'b0;
        m_irq1   = 1'b0;
        m_dat    = '0;
    endtask

    task automatic model_edge();
        logic        req;
        logic        acc;
        logic        bad_now;
        logic [31:0] rd;
        if (wb_rst_i) begin
            model_reset();
            return;
        end
        req = wbs_cyc_i && wbs_stb_i && (wbs_adr_i[31:4] == BASE[31:4]);
        acc = req && !m_ack;
        rd  = model_read(wbs_adr_i[3:2]);
        m_dat  = (acc && !wbs_we_i) ? rd : 32'd0;
        m_ack  = acc;
        m_irq0 = 1'b0;
        m_irq1 = 1'b0;
        if (acc && wbs_we_i && wbs_adr_i[3:2] == 2'd0) begin
            bad_now    = wbs_dat_i[31] && (int'(wbs_dat_i[7:0]) >= NUM_SLOTS);
            m_irq1     = bad_now && !m_bad;
            m_bad      = bad_now;
            m_ctrl     = wbs_dat_i & 32'h8000_00FF;
            m_state    = 1;
            m_deadline = cyc_n + RST_HOLD;
        end else if (m_state == 1 && cyc_n >= m_deadline) begin
            if (m_ctrl[31] && int'(m_ctrl[7:0]) < NUM_SLOTS) begin
                m_state  = 2;
                m_active = m_ctrl[7:0];
                m_cs     = m_staged;
                m_irq0   = 1'b1;
            end else begin
                m_state = 0;
                m_cs    = '0;
            end
        end
        if (acc && wbs_we_i && wbs_adr_i[3:2] == 2'd1) m_staged = wbs_dat_i;
    endtask

    task automatic randomize_slots();
        for (int i = 0; i < NUM_SLOTS; i++) begin
            slot_do[i*IO_W +: IO_W]  = IO_W'({$urandom(), $urandom()});
            slot_oeb[i*IO_W +: IO_W] = IO_W'({$urandom(), $urandom()});
        end
    endtask

    task automatic check_outputs();
        logic [IO_W-1:0]      exp_out;
        logic [IO_W-1:0]      exp_oeb;
        logic [NUM_SLOTS-1:0] exp_rst;
        exp_out = '0;
        exp_oeb = '1;
        exp_rst = '0;
        if (m_state == 2) begin
            exp_out = slot_do[int'(m_active)*IO_W +: IO_W];
            exp_oeb = slot_oeb[int'(m_active)*IO_W +: IO_W];
            exp_rst[m_active] = 1'b1;
        end
        chk("ack", 64'(wbs_ack_o), 64'(m_ack));
        chk("rdata", 64'(wbs_dat_o), 64'(m_dat));
        chk("io_out", 64'(io_out), 64'(exp_out));
        chk("io_oeb", 64'(io_oeb), 64'(exp_oeb));
        chk("slot_rst_n", 64'(slot_rst_n), 64'(exp_rst));
        chk("custom_settings", 64'(custom_settings), 64'(m_cs));
        chk("irq", 64'(irq), 64'({1'b0, m_irq1, m_irq0}));
        if (irq[0]) irq0_seen++;
    endtask

    task automatic step();
        @(posedge wb_clk_i);
        cyc_n++;
        model_edge();
        #1;
        randomize_slots();
        #1;
        check_outputs();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic bus_idle();
        wbs_cyc_i = 1'b0;
        wbs_stb_i = 1'b0;
        wbs_we_i  = 1'b0;
    endtask

    task automatic wb_write(input logic [31:0] a, input logic [31:0] d);
        wbs_cyc_i = 1'b1;
        wbs_stb_i = 1'b1;
        wbs_we_i  = 1'b1;
        wbs_adr_i = a;
        wbs_dat_i = d;
        step();
        bus_idle();
        step();
    endtask

    task automatic wb_read(input logic [31:0] a, output logic [31:0] d);
        wbs_cyc_i = 1'b1;
        wbs_stb_i = 1'b1;
        wbs_we_i  = 1'b0;
        wbs_adr_i = a;
        step();
        d = wbs_dat_o;
        bus_idle();
        step();
    endtask

    logic [31:0] rd;
    logic [3:0]  ack_pat;
    logic [31:0] a_rand;
    logic [31:0] d_rand;

    initial begin
        model_reset();
        wb_rst_i  = 1'b1;
        bus_idle();
        wbs_adr_i = '0;
        wbs_dat_i = '0;
        randomize_slots();
        idle(2);
        wb_rst_i = 1'b0;

        wb_read(BASE + 32'h8, rd);
        chk("status_after_reset", 64'(rd), 64'h0);
        chk("oeb_after_reset", 64'(io_oeb), 64'({IO_W{1'b1}}));

        wb_write(BASE + 32'h4, 32'hA5A5_0001);
        wb_write(BASE + 32'h0, 32'h8000_0003);
        for (int i = 0; i < 10; i++) wb_read(BASE + 32'h8, rd);
        chk("status_run3", 64'(rd), 64'h0000_0302);
        chk("rst_run3", 64'(slot_rst_n), 64'h0008);
        chk("cs_run3", 64'(custom_settings), 64'hA5A5_0001);

        wb_write(BASE + 32'h4, 32'h0000_1234);
        chk("cs_shadowed", 64'(custom_settings), 64'hA5A5_0001);
        wb_write(BASE + 32'h0, 32'h8000_0005);
        idle(20);
        chk("rst_run5", 64'(slot_rst_n), 64'h0020);
        chk("cs_run5", 64'(custom_settings), 64'h1234);

        wb_write(BASE + 32'h0, 32'h8000_0020);
        idle(20);
        wb_read(BASE + 32'h8, rd);
        chk("bad_set", 64'(rd[16]), 64'h1);
        chk("bad_idle", 64'(rd[1:0]), 64'h0);
        wb_write(BASE + 32'h0, 32'h8000_0001);
        wb_read(BASE + 32'h8, rd);
        chk("bad_clr", 64'(rd[16]), 64'h0);
        idle(20);

        irq0_seen = 0;
        wb_write(BASE + 32'h0, 32'h8000_0002);
        idle(14);
        wb_write(BASE + 32'h0, 32'h8000_0004);
        idle(20);
        chk("irq0_count_restart", 64'(irq0_seen), 64'd1);
        chk("rst_run4", 64'(slot_rst_n), 64'h0010);

        wb_rst_i = 1'b1;
        step();
        wb_rst_i = 1'b0;
        chk("rst_oeb", 64'(io_oeb), 64'({IO_W{1'b1}}));
        chk("rst_slot_rst_n", 64'(slot_rst_n), 64'h0);
        wb_read(BASE + 32'h8, rd);
        chk("status_after_midrun_reset", 64'(rd), 64'h0);

        wbs_cyc_i = 1'b1;
        wbs_stb_i = 1'b1;
        wbs_we_i  = 1'b0;
        wbs_adr_i = 32'h3000_0010;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("nomatch_ack", 64'(wbs_ack_o), 64'h0);
        end
        bus_idle();
        step();

        wbs_cyc_i = 1'b1;
        wbs_stb_i = 1'b1;
        wbs_adr_i = BASE + 32'h8;
        for (int i = 0; i < 4; i++) begin
            step();
            ack_pat[i] = wbs_ack_o;
        end
        chk("held_ack_pattern", 64'(ack_pat), 64'h5);
        bus_idle();
        step();

        for (int it = 0; it < 300; it++) begin
            int r;
            r = int'($urandom_range(0, 99));
            if (r < 25) begin
                d_rand = $urandom() & 32'h7FFF_FF00;
                if ($urandom_range(0, 3) != 0) d_rand[31] = 1'b1;
                d_rand[7:0] = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(16, 255))
                                                           : 8'($urandom_range(0, 15));
                wb_write(BASE, d_rand);
            end else if (r < 45) begin
                wb_write(BASE + 32'h4, $urandom());
            end else if (r < 70) begin
                wb_read(BASE + (32'($urandom_range(0, 3)) << 2), rd);
            end else if (r < 75) begin
                wb_write(BASE + (32'($urandom_range(2, 3)) << 2), $urandom());
            end else if (r < 80) begin
                a_rand = $urandom();
                if (a_rand[31:4] == BASE[31:4]) a_rand[31] = ~a_rand[31];
                if ($urandom_range(0, 1) == 0) wb_write(a_rand, $urandom());
                else wb_read(a_rand, rd);
            end else if (r < 82) begin
                wb_rst_i = 1'b1;
                step();
                wb_rst_i = 1'b0;
            end
            idle(int'($urandom_range(0, 18)));
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
